// File: rtl/tensor_core_rf_pkg.sv
// Shared types for the tensor-core matrix bank file: stream FSM states and
// flat-address decoding.
package tensor_core_rf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } stream_state_t;

    typedef struct packed {
        logic [15:0] bank;
        logic [15:0] row;
        logic [15:0] col;
    } elem_coord_t;

    // flat = bank*dim*dim + row*dim + col
    function automatic elem_coord_t addr_to_coord(input int unsigned addr, input int unsigned dim);
        elem_coord_t coord;
        coord.bank = 16'(addr / (dim * dim));
        coord.row  = 16'((addr / dim) % dim);
        coord.col  = 16'(addr % dim);
        return coord;
    endfunction

endpackage

// File: rtl/tensor_core_stream_sequencer.sv
// Stream engine for one bank: IDLE/FILL/DRAIN FSM, row/col beat counters and
// handshakes. TENSOR_CORE_RF_TRANSPOSE_EN adds a column-major beat order.
module tensor_core_stream_sequencer
    import tensor_core_rf_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int BANK_W = 1,
    parameter int CNT_W  = 2
) (
    input  logic              clock_in,
    input  logic              reset_n_in,
    input  logic              start_in,
    input  logic              drain_in,
    input  logic [BANK_W-1:0] bank_in,
`ifdef TENSOR_CORE_RF_TRANSPOSE_EN
    input  logic              transpose_in,
`endif
    input  logic              in_valid_in,
    input  logic              out_ready_in,
    output logic              in_ready_out,
    output logic              out_valid_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              fill_write_out,
    output logic [BANK_W-1:0] bank_out,
    output logic [CNT_W-1:0]  row_out,
    output logic [CNT_W-1:0]  col_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

    stream_state_t     state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic              transpose_q, transpose_d;
    logic              done_q, done_d;
    logic              beat;
    logic              last_beat;

    assign beat      = ((state_q == FILL) && in_valid_in) || ((state_q == DRAIN) && out_ready_in);
    assign last_beat = (row_q == LAST) && (col_q == LAST);

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        transpose_d = transpose_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = drain_in ? DRAIN : FILL;
                    bank_d  = bank_in;
                    row_d   = '0;
                    col_d   = '0;
`ifdef TENSOR_CORE_RF_TRANSPOSE_EN
                    transpose_d = transpose_in;
`else
                    transpose_d = 1'b0;
`endif
                end
            end
            FILL, DRAIN: begin
                if (beat) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (transpose_q) begin
                        // column-major: row is the fast index
                        if (row_q == LAST) begin
                            row_d = '0;
                            col_d = col_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        if (col_q == LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            transpose_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            transpose_q <= transpose_d;
            done_q      <= done_d;
        end
    end

    assign in_ready_out   = (state_q == FILL);
    assign out_valid_out  = (state_q == DRAIN);
    assign busy_out       = (state_q != IDLE);
    assign done_out       = done_q;
    assign fill_write_out = (state_q == FILL) && in_valid_in;
    assign bank_out       = bank_q;
    assign row_out        = row_q;
    assign col_out        = col_q;

endmodule

// File: rtl/tensor_core_matrix_bank_file.sv
// NUM_BANKS x DIM x DIM signed register file with element, bulk and stream
// write paths. TENSOR_CORE_RF_TRANSPOSE_EN adds stream_transpose_in.
module tensor_core_matrix_bank_file
    import tensor_core_rf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 4,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_W     = $clog2(NUM_BANKS * DIM * DIM),
    parameter int BANK_W     = $clog2(NUM_BANKS)
) (
    input  logic                                                  clock_in,
    input  logic                                                  reset_n_in,
`ifdef TENSOR_CORE_RF_TRANSPOSE_EN
    input  logic                                                  stream_transpose_in,
`endif
    input  logic                                                  elem_write_enable_in,
    input  logic [ADDR_W-1:0]                                     elem_write_address_in,
    input  logic [DATA_WIDTH-1:0]                                 elem_write_data_in,
    input  logic [ADDR_W-1:0]                                     elem_read_address_in,
    output logic [DATA_WIDTH-1:0]                                 elem_read_data_out,
    input  logic                                                  bulk_write_enable_in,
    input  logic [BANK_W-1:0]                                     bulk_write_bank_in,
    input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]               bulk_write_data_in,
    output logic [NUM_BANKS-1:0][DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] bulk_read_data_out,
    input  logic                                                  stream_start_in,
    input  logic                                                  stream_drain_in,
    input  logic [BANK_W-1:0]                                     stream_bank_in,
    input  logic                                                  stream_in_valid_in,
    input  logic [DATA_WIDTH-1:0]                                 stream_in_data_in,
    output logic                                                  stream_in_ready_out,
    output logic                                                  stream_out_valid_out,
    output logic [DATA_WIDTH-1:0]                                 stream_out_data_out,
    input  logic                                                  stream_out_ready_in,
    output logic                                                  stream_busy_out,
    output logic                                                  stream_done_out
);

    localparam int TOTAL = NUM_BANKS * DIM * DIM;
    localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;

    logic                          seq_fill_we;
    logic [BANK_W-1:0]             seq_bank;
    logic [CNT_W-1:0]              seq_row;
    logic [CNT_W-1:0]              seq_col;
    logic [ADDR_W-1:0]             drain_idx;
    logic [TOTAL-1:0][DATA_WIDTH-1:0] mem_flat;
    logic [DATA_WIDTH-1:0]         elem_read_q, elem_read_d;

    tensor_core_stream_sequencer #(
        .DIM    (DIM),
        .BANK_W (BANK_W),
        .CNT_W  (CNT_W)
    ) u_seq (
        .clock_in       (clock_in),
        .reset_n_in     (reset_n_in),
        .start_in       (stream_start_in),
        .drain_in       (stream_drain_in),
        .bank_in        (stream_bank_in),
`ifdef TENSOR_CORE_RF_TRANSPOSE_EN
        .transpose_in   (stream_transpose_in),
`endif
        .in_valid_in    (stream_in_valid_in),
        .out_ready_in   (stream_out_ready_in),
        .in_ready_out   (stream_in_ready_out),
        .out_valid_out  (stream_out_valid_out),
        .busy_out       (stream_busy_out),
        .done_out       (stream_done_out),
        .fill_write_out (seq_fill_we),
        .bank_out       (seq_bank),
        .row_out        (seq_row),
        .col_out        (seq_col)
    );

    // One register per element, each with its own bulk > fill > element mux.
    genvar gi;
    generate
        for (gi = 0; gi < TOTAL; gi++) begin : g_elem
            localparam elem_coord_t COORD = addr_to_coord(gi, DIM);
            localparam int EB = int'(COORD.bank);
            localparam int ER = int'(COORD.row);
            localparam int EC = int'(COORD.col);

            logic                  bulk_hit, fill_hit, elem_hit;
            logic [DATA_WIDTH-1:0] elem_q, elem_d;

            assign bulk_hit = bulk_write_enable_in && (int'(bulk_write_bank_in) == EB);
            assign fill_hit = seq_fill_we && (int'(seq_bank) == EB)
                              && (int'(seq_row) == ER) && (int'(seq_col) == EC);
            assign elem_hit = elem_write_enable_in && (int'(elem_write_address_in) == gi);

            always_comb begin
                elem_d = elem_q;
                if (bulk_hit)
                    elem_d = bulk_write_data_in[ER][EC];
                else if (fill_hit)
                    elem_d = stream_in_data_in;
                else if (elem_hit)
                    elem_d = elem_write_data_in;
            end

            always_ff @(posedge clock_in or negedge reset_n_in) begin
                if (!reset_n_in)
                    elem_q <= '0;
                else
                    elem_q <= elem_d;
            end

            assign mem_flat[gi]                   = elem_q;
            assign bulk_read_data_out[EB][ER][EC] = elem_q;
        end
    endgenerate

    always_comb begin
        elem_read_d = '0;
        if (int'(elem_read_address_in) < TOTAL)
            elem_read_d = mem_flat[elem_read_address_in];
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in)
            elem_read_q <= '0;
        else
            elem_read_q <= elem_read_d;
    end

    assign elem_read_data_out = elem_read_q;

    assign drain_idx = ADDR_W'(int'(seq_bank) * DIM * DIM + int'(seq_row) * DIM + int'(seq_col));
    assign stream_out_data_out = stream_out_valid_out ? mem_flat[drain_idx] : '0;

endmodule

// File: tb/tb_tensor_core_matrix_bank_file.sv
// Directed self-checking bench for tensor_core_matrix_bank_file (DW=8, DIM=4,
// 2 banks); the transpose case is built only with TENSOR_CORE_RF_TRANSPOSE_EN.
module tb_tensor_core_matrix_bank_file;

    logic                         clk;
    logic                         rst_n;
    logic                         stream_transpose;
    logic                         ew_en;
    logic [4:0]                   ew_addr;
    logic [7:0]                   ew_data;
    logic [4:0]                   er_addr;
    logic [7:0]                   er_data;
    logic                         bw_en;
    logic                         bw_bank;
    logic [3:0][3:0][7:0]         bw_data;
    logic [1:0][3:0][3:0][7:0]    bulk_rd;
    logic                         s_start;
    logic                         s_drain;
    logic                         s_bank;
    logic                         s_in_valid;
    logic [7:0]                   s_in_data;
    logic                         s_in_ready;
    logic                         s_out_valid;
    logic [7:0]                   s_out_data;
    logic                         s_out_ready;
    logic                         s_busy;
    logic                         s_done;

    int checks   = 0;
    int failures = 0;

    tensor_core_matrix_bank_file #(
        .DATA_WIDTH (8),
        .DIM        (4),
        .NUM_BANKS  (2)
    ) dut (
        .clock_in              (clk),
        .reset_n_in            (rst_n),
`ifdef TENSOR_CORE_RF_TRANSPOSE_EN
        .stream_transpose_in   (stream_transpose),
`endif
        .elem_write_enable_in  (ew_en),
        .elem_write_address_in (ew_addr),
        .elem_write_data_in    (ew_data),
        .elem_read_address_in  (er_addr),
        .elem_read_data_out    (er_data),
        .bulk_write_enable_in  (bw_en),
        .bulk_write_bank_in    (bw_bank),
        .bulk_write_data_in    (bw_data),
        .bulk_read_data_out    (bulk_rd),
        .stream_start_in       (s_start),
        .stream_drain_in       (s_drain),
        .stream_bank_in        (s_bank),
        .stream_in_valid_in    (s_in_valid),
        .stream_in_data_in     (s_in_data),
        .stream_in_ready_out   (s_in_ready),
        .stream_out_valid_out  (s_out_valid),
        .stream_out_data_out   (s_out_data),
        .stream_out_ready_in   (s_out_ready),
        .stream_busy_out       (s_busy),
        .stream_done_out       (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    initial begin
        int done_cnt;
        int done_k;
        int beat;
        int stall;

        rst_n = 1'b0; stream_transpose = 1'b0;
        ew_en = 1'b0; ew_addr = '0; ew_data = '0; er_addr = '0;
        bw_en = 1'b0; bw_bank = 1'b0; bw_data = '0;
        s_start = 1'b0; s_drain = 1'b0; s_bank = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_bulk_any", 32'(|bulk_rd), 32'h0);
        check("rst_rd_data", 32'(er_data), 32'h0);
        check("rst_busy", 32'(s_busy), 32'h0);
        check("rst_in_ready", 32'(s_in_ready), 32'h0);
        check("rst_out_valid", 32'(s_out_valid), 32'h0);
        check("rst_done", 32'(s_done), 32'h0);
        rst_n = 1'b1;

        // element write -8 @21 with same-cycle read of 21
        ew_en = 1'b1; ew_addr = 5'd21; ew_data = 8'hF8; er_addr = 5'd21;
        @(negedge clk);
        check("ew_bulk_1_1_1", 32'(bulk_rd[1][1][1]), 32'hF8);
        check("ew_read_before_write", 32'(er_data), 32'h0);
        ew_en = 1'b0;
        @(negedge clk);
        check("ew_read_21", 32'(er_data), 32'hF8);

        // bulk bank 0 = 0..15 beats element write @3
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bw_data[r][c] = 8'(r * 4 + c);
        bw_en = 1'b1; bw_bank = 1'b0;
        ew_en = 1'b1; ew_addr = 5'd3; ew_data = 8'h55;
        @(negedge clk);
        check("bulk_0_0_3_wins", 32'(bulk_rd[0][0][3]), 32'h03);
        check("bulk_0_2_1", 32'(bulk_rd[0][2][1]), 32'h09);
        check("bulk_bank1_kept", 32'(bulk_rd[1][1][1]), 32'hF8);
        // bulk to bank 0 and element write to bank 1 both land
        ew_addr = 5'd17; ew_data = 8'h33;
        bw_data[0][1] = 8'h44;
        @(negedge clk);
        bw_en = 1'b0; ew_en = 1'b0;
        check("elem_other_bank", 32'(bulk_rd[1][0][1]), 32'h33);
        check("bulk_same_cycle", 32'(bulk_rd[0][0][1]), 32'h44);

        // fill bank 1, valid every other cycle, start while busy ignored
        s_start = 1'b1; s_drain = 1'b0; s_bank = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("fill_busy", 32'(s_busy), 32'h1);
        check("fill_ready", 32'(s_in_ready), 32'h1);
        done_cnt = 0; done_k = -1;
        for (int k = 0; k < 34; k++) begin
            if (s_done) begin done_cnt++; done_k = k; end
            s_in_valid = (k < 32) && (k % 2 == 0);
            s_in_data  = 8'(k / 2 + 1);
            ew_en      = (k == 0);
            ew_addr    = 5'd16; ew_data = 8'h77;
            s_start    = (k == 4); s_drain = 1'b1; s_bank = 1'b0;
            @(negedge clk);
        end
        s_in_valid = 1'b0; ew_en = 1'b0; s_start = 1'b0;
        check("fill_done_count", 32'(done_cnt), 32'd1);
        check("fill_done_cycle", 32'(done_k), 32'd31);
        check("fill_1_3_3", 32'(bulk_rd[1][3][3]), 32'h10);
        check("fill_beats_elem", 32'(bulk_rd[1][0][0]), 32'h01);
        check("fill_1_0_1", 32'(bulk_rd[1][0][1]), 32'h02);
        check("fill_1_1_1", 32'(bulk_rd[1][1][1]), 32'h06);
        check("fill_bank0_kept", 32'(bulk_rd[0][0][3]), 32'h03);
        check("fill_idle", 32'(s_busy), 32'h0);

        // drain bank 1, ready low 3 cycles at beat 5
        s_start = 1'b1; s_drain = 1'b1; s_bank = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        beat = 0; stall = 0; done_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (s_done) done_cnt++;
            if (beat < 16) begin
                check($sformatf("drain_valid_b%0d", beat), 32'(s_out_valid), 32'h1);
                if (beat == 5 && stall < 3) begin
                    s_out_ready = 1'b0;
                    check($sformatf("drain_hold_s%0d", stall), 32'(s_out_data), 32'h06);
                    stall++;
                end else begin
                    s_out_ready = 1'b1;
                    check($sformatf("drain_data_b%0d", beat), 32'(s_out_data), 32'(beat + 1));
                    beat++;
                end
            end else begin
                s_out_ready = 1'b0;
            end
            @(negedge clk);
        end
        check("drain_done_count", 32'(done_cnt), 32'd1);
        check("drain_idle", 32'(s_busy), 32'h0);

        // reset at fill beat 7
        s_start = 1'b1; s_drain = 1'b0; s_bank = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s_in_valid = 1'b1; s_in_data = 8'(8'h40 + k);
            @(negedge clk);
        end
        s_in_data = 8'h47;
        #1 rst_n = 1'b0;
        #1;
        check("abort_bulk_any", 32'(|bulk_rd), 32'h0);
        check("abort_busy", 32'(s_busy), 32'h0);
        check("abort_ready", 32'(s_in_ready), 32'h0);
        check("abort_done", 32'(s_done), 32'h0);
        check("abort_out_data", 32'(s_out_data), 32'h0);
        check("abort_rd_data", 32'(er_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; s_in_valid = 1'b0;
        s_start = 1'b1; s_drain = 1'b0; s_bank = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        check("restart_busy", 32'(s_busy), 32'h1);
        check("restart_ready", 32'(s_in_ready), 32'h1);
        check("restart_no_done", 32'(s_done), 32'h0);
        for (int k = 0; k < 16; k++) begin
            s_in_valid = 1'b1; s_in_data = 8'(8'hA0 + k);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        check("restart_done", 32'(s_done), 32'h1);
        check("restart_0_0_0", 32'(bulk_rd[0][0][0]), 32'hA0);
        check("restart_0_3_3", 32'(bulk_rd[0][3][3]), 32'hAF);
        check("restart_0_1_2", 32'(bulk_rd[0][1][2]), 32'hA6);

`ifdef TENSOR_CORE_RF_TRANSPOSE_EN
        // column-major fill of bank 0 loads the transpose
        s_start = 1'b1; s_drain = 1'b0; s_bank = 1'b0; stream_transpose = 1'b1;
        @(negedge clk);
        s_start = 1'b0; stream_transpose = 1'b0;
        for (int k = 0; k < 16; k++) begin
            s_in_valid = 1'b1; s_in_data = 8'(k + 1);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        check("tr_done", 32'(s_done), 32'h1);
        check("tr_0_0_1", 32'(bulk_rd[0][0][1]), 32'h05);
        check("tr_0_1_0", 32'(bulk_rd[0][1][0]), 32'h02);
        check("tr_0_3_2", 32'(bulk_rd[0][3][2]), 32'h0C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
